// File: rtl/rc5_decryptor_if.sv
// Interface bundle for rc5_decryptor: start/operand request, S-memory read port, result.
// The master side is the requester and the S-memory that answers the reads.
// Optional macro: RC5_DEC_ENCRYPT_EN adds the iEncrypt mode select.
interface rc5_decryptor_if #(
  parameter int W        = 32,
  parameter int T_LENGTH = 5
);
  logic                iStart;
  logic [W-1:0]        iA;
  logic [W-1:0]        iB;
  logic [T_LENGTH-1:0] oS_address;
  logic [W-1:0]        iS_sub_i;
  logic [W-1:0]        oA;
  logic [W-1:0]        oB;
  logic                oBusy;
  logic                oDone;
`ifdef RC5_DEC_ENCRYPT_EN
  logic                iEncrypt;

  modport master (output iStart, iA, iB, iS_sub_i, iEncrypt,
                  input  oS_address, oA, oB, oBusy, oDone);
  modport slave  (input  iStart, iA, iB, iS_sub_i, iEncrypt,
                  output oS_address, oA, oB, oBusy, oDone);
`else
  modport master (output iStart, iA, iB, iS_sub_i,
                  input  oS_address, oA, oB, oBusy, oDone);
  modport slave  (input  iStart, iA, iB, iS_sub_i,
                  output oS_address, oA, oB, oBusy, oDone);
`endif
endinterface

// File: rtl/rc5_decryptor.sv
// Iterative RC5-W/R/b block decryptor. Reads the expanded key table S from a
// synchronous-read memory (1-cycle latency), one word per two-cycle slot,
// highest address first, and recovers the plaintext block.
// Optional macro: RC5_DEC_ENCRYPT_EN adds an encrypt mode (iEncrypt) that reuses
// the same state skeleton with ascending addresses.
module rc5_decryptor #(
  parameter int W        = 32,
  parameter int R        = 12,
  parameter int T        = 26,
  parameter int T_LENGTH = $clog2(T)
) (
  input logic           clk,
  input logic           rst,
  rc5_decryptor_if.slave bus
);
  localparam int LOG_W = $clog2(W);
  localparam int RW    = $clog2(R + 1);

  typedef enum logic [3:0] {
    IDLE, WAIT_B, OP_B, WAIT_A, OP_A, WAIT_F1, SUB_B, WAIT_F0, SUB_A, DONE
  } state_t;

  state_t              state;
  logic [W-1:0]        aReg, bReg;
  logic [RW-1:0]       roundCnt;
  logic [T_LENGTH-1:0] addrReg;
  logic [W-1:0]        oAReg, oBReg;
  logic                busyReg, doneReg;
  logic                encryptMode;
  logic [W-1:0]        slotB, slotA;
  logic [T_LENGTH-1:0] nextAddr;

`ifdef RC5_DEC_ENCRYPT_EN
  logic encryptReg;
  assign encryptMode = encryptReg;
`else
  assign encryptMode = 1'b0;
`endif

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LOG_W-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} >> n;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LOG_W-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  // The memory word being consumed always belongs to the address still on
  // oS_address, because the address only moves on the edge that ends an op slot.
  // "B slot" states (OP_B, SUB_B) and "A slot" states (OP_A, SUB_A) each
  // compute one word; which register it lands in depends on the mode.
  always_comb begin
    slotB = '0;
    slotA = '0;
    if (encryptMode) begin
      slotB = (addrReg == '0) ? aReg + bus.iS_sub_i
                              : rotl(aReg ^ bReg, bReg[LOG_W-1:0]) + bus.iS_sub_i;
      slotA = (addrReg == T_LENGTH'(1)) ? bReg + bus.iS_sub_i
                                        : rotl(bReg ^ aReg, aReg[LOG_W-1:0]) + bus.iS_sub_i;
    end else begin
      slotB = (state == SUB_B) ? bReg - bus.iS_sub_i
                               : rotr(bReg - bus.iS_sub_i, aReg[LOG_W-1:0]) ^ aReg;
      slotA = (state == SUB_A) ? aReg - bus.iS_sub_i
                               : rotr(aReg - bus.iS_sub_i, bReg[LOG_W-1:0]) ^ bReg;
    end
    nextAddr = encryptMode ? addrReg + T_LENGTH'(1) : addrReg - T_LENGTH'(1);
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      roundCnt <= RW'(R);
      aReg     <= '0;
      bReg     <= '0;
      addrReg  <= '0;
      oAReg    <= '0;
      oBReg    <= '0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
`ifdef RC5_DEC_ENCRYPT_EN
      encryptReg <= 1'b0;
`endif
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            aReg     <= bus.iA;
            bReg     <= bus.iB;
            roundCnt <= RW'(R);
            busyReg  <= 1'b1;
            state    <= WAIT_B;
`ifdef RC5_DEC_ENCRYPT_EN
            encryptReg <= bus.iEncrypt;
            addrReg    <= bus.iEncrypt ? '0 : T_LENGTH'(T - 1);
`else
            addrReg    <= T_LENGTH'(T - 1);
`endif
          end
        end
        WAIT_B: state <= OP_B;
        OP_B: begin
          if (encryptMode) aReg <= slotB;
          else             bReg <= slotB;
          addrReg <= nextAddr;
          state   <= WAIT_A;
        end
        WAIT_A: state <= OP_A;
        OP_A: begin
          if (encryptMode) bReg <= slotA;
          else             aReg <= slotA;
          addrReg <= nextAddr;
          if (roundCnt > RW'(1)) begin
            roundCnt <= roundCnt - RW'(1);
            state    <= WAIT_B;
          end else begin
            state <= WAIT_F1;
          end
        end
        WAIT_F1: state <= SUB_B;
        SUB_B: begin
          if (encryptMode) aReg <= slotB;
          else             bReg <= slotB;
          addrReg <= nextAddr;
          state   <= WAIT_F0;
        end
        WAIT_F0: state <= SUB_A;
        SUB_A: begin
          // Results are registered here so they are valid alongside the done pulse.
          if (encryptMode) begin
            bReg  <= slotA;
            oAReg <= aReg;
            oBReg <= slotA;
          end else begin
            aReg  <= slotA;
            oAReg <= slotA;
            oBReg <= bReg;
          end
          doneReg <= 1'b1;
          busyReg <= 1'b0;
          state   <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oS_address = addrReg;
  assign bus.oA         = oAReg;
  assign bus.oB         = oBReg;
  assign bus.oBusy      = busyReg;
  assign bus.oDone      = doneReg;
endmodule
